// File: rtl/cmp_pkg.sv
// ---------------------------------------------------------------------------
// cmp_pkg : shared types and constants for the sequential comparator
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cmp_pkg;

  localparam int SLICE_W = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cmp2bit.sv
// ---------------------------------------------------------------------------
// cmp2bit : 2-bit unsigned magnitude comparator slice
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cmp2bit
  import cmp_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  output logic               eq,
  output logic               gt,
  output logic               lt
);

  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);

endmodule

`default_nettype wire

// File: rtl/cmp_seq_ctrl.sv
// ---------------------------------------------------------------------------
// cmp_seq_ctrl : compares two WIDTH-bit operands one 2-bit slice per clock
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cmp_seq_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic             more,
  output logic             less
);

  localparam int N     = WIDTH / SLICE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             sl_eq;
  logic             sl_gt;
  logic             sl_lt;
  logic             accept;
  logic             finish;

  // Shift the active slice down to bit 0 so a single comparator serves every idx
  assign a_sh = a_q >> {idx, 1'b0};
  assign b_sh = b_q >> {idx, 1'b0};

  cmp2bit u_slice (
    .a  (a_sh[SLICE_W-1:0]),
    .b  (b_sh[SLICE_W-1:0]),
    .eq (sl_eq),
    .gt (sl_gt),
    .lt (sl_lt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (!sl_eq || (idx == '0)) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SCAN);
  end

  // Results load straight from the slice: an equal final slice yields 1/0/0
  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      done  <= 1'b0;
      equal <= 1'b0;
      more  <= 1'b0;
      less  <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        a_q <= A;
        b_q <= B;
        idx <= IDX_TOP;
      end else if ((state == SCAN) && !finish) begin
        idx <= idx - 1'b1;
      end
      if (finish) begin
        equal <= sl_eq;
        more  <= sl_gt;
        less  <= sl_lt;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cmp_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cmp_seq_ctrl : scoreboard bench for the sequential comparator
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_cmp_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int N     = WIDTH / 2;

  logic             clk   = 1'b0;
  logic             rst   = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a_in  = '0;
  logic [WIDTH-1:0] b_in  = '0;
  logic             busy;
  logic             done;
  logic             equal;
  logic             more;
  logic             less;

  always #5 clk = ~clk;

  cmp_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a_in),
    .B     (b_in),
    .busy  (busy),
    .done  (done),
    .equal (equal),
    .more  (more),
    .less  (less)
  );

  typedef struct {
    int   edge_n;
    logic eq;
    logic gt;
    logic lt;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int first_diff(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    for (int s = N - 1; s >= 0; s--) begin
      if (a[2*s +: 2] != b[2*s +: 2]) return N - s;
    end
    return N;
  endfunction

  // One rising edge; any done seen is matched against the scoreboard head
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("done_edge", cyc, e.edge_n);
        chk("equal", 32'(equal), 32'(e.eq));
        chk("more", 32'(more), 32'(e.gt));
        chk("less", 32'(less), 32'(e.lt));
      end
    end
  endtask

  task automatic go(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    a_in     = a;
    b_in     = b;
    start    = 1'b1;
    e.edge_n = cyc + 1 + first_diff(a, b);
    e.eq     = (a == b);
    e.gt     = (a > b);
    e.lt     = (a < b);
    sb.push_back(e);
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((sb.size() != 0) && (n < max_cyc)) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout_pending", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    exp_t e;
    int   base;

    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_equal", 32'(equal), 32'd0);
    chk("rst_more", 32'(more), 32'd0);
    chk("rst_less", 32'(less), 32'd0);
    rst = 1'b0;
    tick();

    // Equal operands: full-length scan
    go(8'hA5, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("busy_scan", 32'(busy), 32'd1);
    end
    drain(8);
    chk("busy_after_done", 32'(busy), 32'd0);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);

    // MSB slice decides; result must hold afterwards
    go(8'h80, 8'h7F);
    drain(8);
    repeat (3) tick();
    chk("hold_more", 32'(more), 32'd1);
    chk("hold_equal", 32'(equal), 32'd0);

    // Operand changes after acceptance are ignored
    go(8'h12, 8'h13);
    a_in = 8'hFF;
    b_in = 8'hFF;
    drain(8);
    tick();

    // start while busy is ignored
    go(8'h40, 8'h40);
    a_in  = 8'h01;
    b_in  = 8'h02;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    drain(8);
    repeat (2) tick();

    // Reset mid-scan aborts without a done
    go(8'h30, 8'h31);
    tick();
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_equal", 32'(equal), 32'd0);
    chk("abort_more", 32'(more), 32'd0);
    chk("abort_less", 32'(less), 32'd0);
    go(8'h01, 8'h00);
    drain(8);
    tick();

    // start held high: one comparison every two edges
    a_in  = 8'hC0;
    b_in  = 8'h40;
    start = 1'b1;
    base  = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      e.edge_n = base + 1 + 2 * i;
      e.eq     = 1'b0;
      e.gt     = 1'b1;
      e.lt     = 1'b0;
      sb.push_back(e);
    end
    repeat (7) tick();
    start = 1'b0;
    drain(4);
    tick();
    chk("hold_idle_busy", 32'(busy), 32'd0);

    // Random operands, high byte often shared to exercise longer scans
    for (int i = 0; i < 8; i++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      ra = WIDTH'($urandom);
      rb = (i % 2 == 0) ? {ra[WIDTH-1:4], 4'($urandom)} : WIDTH'($urandom);
      go(ra, rb);
      drain(8);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
